// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_tgt_state_t;

    // Byte shifted out on MISO when nothing is queued for transmit.
    localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_target_if.sv
// Bundles the SPI pins and the local RX/TX byte-stream handshakes.
// The slave modport is the target's view; master is the far-end/local user view.
interface spi_target_if;

    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       overrun;
    logic       underrun;

    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n, rx_ready, tx_data, tx_valid,
        output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, busy, overrun, underrun
    );

    modport master (
        output spi_sck, spi_mosi, spi_cs_n, rx_ready, tx_data, tx_valid,
        input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, busy, overrun, underrun
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous input bit.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the async input through the flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {STAGES{RESET_VAL}};
        else       sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples SCK/MOSI/CS_N, deserialises MOSI into bytes,
// serialises queued TX bytes onto MISO MSB first. Single-entry RX/TX buffers.
// Optional: define SPI_TGT_STATS_EN to add saturating byte/error counters.
module spi_target
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    spi_target_if.slave bus
`ifdef SPI_TGT_STATS_EN
    ,
    output logic [15:0] stat_bytes,
    output logic [15:0] stat_errs
`endif
);

    logic           sck_s, mosi_s, cs_n_s;
    logic           sck_d, cs_n_d;
    logic           sck_rise, sck_fall, cs_fall, cs_rise;
    spi_tgt_state_t state_q, state_d;
    logic           frame_start, frame_end, do_rise, do_fall;
    logic [2:0]     bit_cnt;
    logic [6:0]     rx_sh;
    logic [6:0]     tx_sh;      // bits still to send after the one on MISO
    logic [7:0]     tx_hold;
    logic           tx_full;
    logic [7:0]     rx_data_q;
    logic           rx_valid_q;
    logic           miso_q, oe_q, ovr_q, und_q;
    logic [7:0]     rx_byte, load_byte;
    logic           byte_done, reload, rx_take, ovr_d, und_d;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck  (.clk(clk), .reset(reset), .d(bus.spi_sck),  .q(sck_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(bus.spi_mosi), .q(mosi_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(bus.spi_cs_n), .q(cs_n_s));

    // Delayed copies of synced SCK/CS_N for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_d  <= 1'b0;
            cs_n_d <= 1'b1;
        end else begin
            sck_d  <= sck_s;
            cs_n_d <= cs_n_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_n_s & cs_n_d;
    assign cs_rise  = cs_n_s & ~cs_n_d;

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle strobes; CS_N release beats any SCK edge.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        do_rise     = 1'b0;
        do_fall     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end else begin
                    do_rise = sck_rise;
                    do_fall = sck_fall;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_byte   = {rx_sh, mosi_s};
    assign byte_done = do_rise && (bit_cnt == 3'd7);
    assign rx_take   = byte_done && (!rx_valid_q || bus.rx_ready);
    assign ovr_d     = byte_done && !rx_take;
    assign reload    = frame_start || (do_fall && (bit_cnt == 3'd0));
    assign load_byte = tx_full ? tx_hold : IDLE_BYTE;
    assign und_d     = reload && !tx_full;

    // Receive shifter, bit counter and the single-entry RX buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            rx_sh      <= 7'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            if (frame_start) begin
                bit_cnt <= 3'd0;
            end else if (do_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_byte[6:0];
            end
            if (rx_take) begin
                rx_data_q  <= rx_byte;
                rx_valid_q <= 1'b1;
            end else if (bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    // Transmit shifter and MISO drive; reload at frame start and byte boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sh  <= 7'd0;
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
            und_q  <= 1'b0;
        end else begin
            und_q <= und_d;
            if (frame_end) begin
                miso_q <= 1'b0;
                oe_q   <= 1'b0;
            end else if (reload) begin
                tx_sh  <= load_byte[6:0];
                miso_q <= load_byte[7];
                oe_q   <= 1'b1;
            end else if (do_fall) begin
                tx_sh  <= {tx_sh[5:0], 1'b0};
                miso_q <= tx_sh[6];
            end
        end
    end

    // TX holding register: filled by the handshake, emptied by a reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_hold <= 8'd0;
            tx_full <= 1'b0;
        end else if (bus.tx_valid && !tx_full) begin
            tx_hold <= bus.tx_data;
            tx_full <= 1'b1;
        end else if (reload) begin
            tx_full <= 1'b0;
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_ready    = ~tx_full;
    assign bus.busy        = (state_q == ACTIVE);
    assign bus.overrun     = ovr_q;
    assign bus.underrun    = und_q;

`ifdef SPI_TGT_STATS_EN
    logic [15:0] bytes_q, errs_q;

    // Saturating counters of completed bytes and overrun/underrun events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bytes_q <= 16'd0;
            errs_q  <= 16'd0;
        end else begin
            if (byte_done)      bytes_q <= sat_inc16(bytes_q);
            if (ovr_d || und_d) errs_q  <= sat_inc16(errs_q);
        end
    end

    assign stat_bytes = bytes_q;
    assign stat_errs  = errs_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a byte-level model of the TX/RX buffers checked
// against the DUT, directed scenarios plus randomized frames.
module tb_spi_target;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 6;   // SCK half period in clk cycles

    logic clk   = 1'b0;
    logic reset = 1'b1;
    spi_target_if bus();

    spi_target #(.SYNC_STAGES(SYNC_STAGES), .IDLE_BYTE(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic       m_tx_full  = 1'b0;
    logic [7:0] m_tx_hold  = 8'd0;
    logic       m_rx_valid = 1'b0;
    logic [7:0] m_rx_data  = 8'd0;
    int         m_ovr      = 0;
    int         m_und      = 0;
    logic       chk_en     = 1'b0;
    logic [7:0] last_miso  = 8'd0;

    // Pulse counters observed on the DUT
    int n_ovr = 0;
    int n_und = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.overrun)  n_ovr++;
            if (bus.underrun) n_und++;
        end
    end

    // Steady-state comparison between transactions.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("rx_valid", bus.rx_valid, m_rx_valid);
            check("rx_data",  bus.rx_data,  m_rx_data);
            check("tx_ready", bus.tx_ready, !m_tx_full);
            check("busy_idle", bus.busy, 1'b0);
            check("oe_idle",   bus.spi_miso_oe, 1'b0);
            check("miso_idle", bus.spi_miso, 1'b0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_load(output logic [7:0] b);
        if (m_tx_full) begin
            b = m_tx_hold;
            m_tx_full = 1'b0;
        end else begin
            b = 8'hFF;
            m_und++;
        end
    endtask

    task automatic model_rx(input logic [7:0] b, input bit ready);
        if (!m_rx_valid || ready) begin
            m_rx_data  = b;
            m_rx_valid = 1'b1;
        end else begin
            m_ovr++;
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        check("tx_ready_pre_push", bus.tx_ready, !m_tx_full);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        if (!m_tx_full) begin
            m_tx_hold = b;
            m_tx_full = 1'b1;
        end
    endtask

    task automatic consume();
        check("consume_valid", bus.rx_valid, m_rx_valid);
        check("consume_data",  bus.rx_data,  m_rx_data);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        m_rx_valid = 1'b0;
    endtask

    // Master-side frame: nbits bits MSB first from b0,b1,b2; the final SCK fall
    // and CS_N release happen together. ready_pulse asserts rx_ready for the
    // single clk in which the last byte lands.
    task automatic run_frame(input int nbits, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input bit ready_pulse);
        logic [7:0] mb [3];
        logic [7:0] exp_tx;
        logic [7:0] cap;
        int idx, bp;
        bit last;
        mb[0] = b0; mb[1] = b1; mb[2] = b2;
        cap = 8'd0;
        chk_en = 1'b0;
        bus.spi_cs_n = 1'b0;
        model_load(exp_tx);
        tick(SYNC_STAGES + 4);
        check("busy_in_frame", bus.busy, 1'b1);
        check("oe_in_frame",   bus.spi_miso_oe, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            idx  = i / 8;
            bp   = 7 - (i % 8);
            last = (i == nbits - 1);
            if ((i % 8 == 0) && (i > 0)) model_load(exp_tx);
            bus.spi_mosi = mb[idx][bp];
            tick(HALF);
            cap[bp] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            if (bp == 0) begin
                model_rx(mb[idx], ready_pulse && last);
                check("miso_byte", cap, exp_tx);
                last_miso = cap;
            end
            if (ready_pulse && last && bp == 0) begin
                tick(SYNC_STAGES);
                bus.rx_ready = 1'b1;
                tick(1);
                bus.rx_ready = 1'b0;
                tick(HALF - SYNC_STAGES - 1);
            end else begin
                tick(HALF);
            end
            bus.spi_sck = 1'b0;
            if (last) bus.spi_cs_n = 1'b1;
        end
        tick(SYNC_STAGES + 4);
        chk_en = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},     bus.spi_miso, 1'b0);
        check({tag, "_oe"},       bus.spi_miso_oe, 1'b0);
        check({tag, "_rx_data"},  bus.rx_data, 8'h00);
        check({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
        check({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
        check({tag, "_busy"},     bus.busy, 1'b0);
        check({tag, "_overrun"},  bus.overrun, 1'b0);
        check({tag, "_underrun"}, bus.underrun, 1'b0);
    endtask

    initial begin
        int nb, nbits;
        logic [7:0] r0, r1, r2;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.rx_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'd0;
        reset = 1'b1;
        tick(3);
        check_reset_values("reset");
        reset = 1'b0;
        tick(4);
        chk_en = 1'b1;

        // 1: queued A5 out, 3C in
        push_tx(8'hA5);
        run_frame(8, 8'h3C, 8'h00, 8'h00, 1'b0);
        check("t1_miso", last_miso, 8'hA5);
        check("t1_rx_data", bus.rx_data, 8'h3C);
        check("t1_rx_valid", bus.rx_valid, 1'b1);
        check("t1_underruns", n_und, 0);
        consume();

        // 2: nothing queued -> idle byte, one underrun
        run_frame(8, 8'h00, 8'h00, 8'h00, 1'b0);
        check("t2_miso", last_miso, 8'hFF);
        check("t2_underruns", n_und, 1);
        consume();

        // 3: two bytes without consuming -> second dropped
        run_frame(16, 8'h11, 8'h22, 8'h00, 1'b0);
        check("t3_rx_data", bus.rx_data, 8'h11);
        check("t3_overruns", n_ovr, 1);
        check("t3_underruns", n_und, 3);
        consume();

        // 4: partial frame discarded, then a full one
        push_tx(8'h99);
        run_frame(5, 8'hF0, 8'h00, 8'h00, 1'b0);
        check("t4_no_rx_valid", bus.rx_valid, 1'b0);
        run_frame(8, 8'h5A, 8'h00, 8'h00, 1'b0);
        check("t4_rx_data", bus.rx_data, 8'h5A);
        check("t4_tx_ready", bus.tx_ready, 1'b1);
        check("t4_overruns", n_ovr, 1);
        consume();

        // 5: consumer ready in the landing clk -> replace, no overrun
        run_frame(8, 8'h42, 8'h00, 8'h00, 1'b0);
        run_frame(8, 8'h77, 8'h00, 8'h00, 1'b1);
        check("t5_rx_data", bus.rx_data, 8'h77);
        check("t5_rx_valid", bus.rx_valid, 1'b1);
        check("t5_overruns", n_ovr, 1);

        // 6: reset mid-byte with RX valid and TX queued
        chk_en = 1'b0;
        bus.spi_cs_n = 1'b0;
        model_load(r0);
        tick(SYNC_STAGES + 4);
        push_tx(8'hC3);
        for (int i = 0; i < 3; i++) begin
            bus.spi_mosi = i[0];
            tick(HALF);
            bus.spi_sck = 1'b1;
            tick(HALF);
            bus.spi_sck = 1'b0;
        end
        tick(2);
        reset = 1'b1;
        bus.spi_cs_n = 1'b1;
        tick(1);
        check_reset_values("midreset");
        m_tx_full = 1'b0;
        m_rx_valid = 1'b0;
        m_rx_data = 8'd0;
        tick(2);
        reset = 1'b0;
        tick(4);
        chk_en = 1'b1;
        run_frame(8, 8'h3C, 8'h00, 8'h00, 1'b0);
        check("t6_rx_data", bus.rx_data, 8'h3C);
        check("t6_rx_valid", bus.rx_valid, 1'b1);
        consume();

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            nb = $urandom_range(0, 2);
            for (int k = 0; k < nb; k++) push_tx(8'($urandom));
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 23) : 8 * $urandom_range(1, 3);
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
            run_frame(nbits, r0, r1, r2, 1'b0);
            if ($urandom_range(0, 9) < 7) consume();
            tick($urandom_range(1, 5));
        end

        check("total_overruns", n_ovr, m_ovr);
        check("total_underruns", n_und, m_und);
        chk_en = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
